cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter_pkg.sv | 30 +++
 rtl/cdb_arbiter_rr_pick.sv | 38 +++
 rtl/cdb_arbiter.sv | 107 ++++++++++
 tb/tb_cdb_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cdb_arbiter_pkg                                               |
// | Brief    : Shared CDB widths, station label constants and helpers.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package cdb_arbiter_pkg;

    localparam int c_N_REQ = 3;
    localparam int c_LW    = 5;
    localparam int c_DW    = 32;

    typedef logic [c_LW-1:0] label_t;

    // Label 0 is reserved as "no tag"; stations are numbered from 1.
    localparam label_t c_NO_TAG = 5'd0;
    localparam label_t c_ADD0   = 5'd1;
    localparam label_t c_ADD1   = 5'd2;
    localparam label_t c_ADD2   = 5'd3;
    localparam label_t c_MULT0  = 5'd4;
    localparam label_t c_MULT1  = 5'd5;
    localparam label_t c_LOAD0  = 5'd6;
    localparam label_t c_LOAD1  = 5'd7;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cdb_arbiter_rr_pick                                           |
// | Brief    : Rotate-priority picker: first set bit of elig from ptr up.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module cdb_arbiter_rr_pick
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ = c_N_REQ,
    parameter int PW    = ptr_width(c_N_REQ)
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [PW-1:0]    ptr,
    output logic             found,
    output logic [PW-1:0]    idx
);

    function automatic int wrap_pos(input int p, input int k);
        int s;
        s = p + k;
        return (s >= N_REQ) ? s - N_REQ : s;
    endfunction

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Scan farthest offset first so the nearest eligible index overrides.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (elig[wrap_pos(int'(ptr), k)]) begin
                found = 1'b1;
                idx   = PW'(wrap_pos(int'(ptr), k));
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cdb_arbiter                                                   |
// | Brief    : Round-robin CDB grant with registered broadcast and holdoff.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ = c_N_REQ,
    parameter int DW    = c_DW,
    parameter int LW    = c_LW
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*LW-1:0]   req_label,
    input  logic [N_REQ*DW-1:0]   req_data,
    output logic [N_REQ-1:0]      ack,
    output logic                  BCEN,
    output logic [LW-1:0]         BClabel,
    output logic [DW-1:0]         BCdata,
    output logic                  err_label0,
    output logic [15:0]           bc_count
);

    localparam int c_PW = ptr_width(N_REQ);

    logic [N_REQ-1:0] r_ack;
    logic [N_REQ-1:0] r_holdoff;
    logic [c_PW-1:0]  r_ptr;
    logic             r_bcen;
    logic [LW-1:0]    r_bclabel;
    logic [DW-1:0]    r_bcdata;
    logic             r_err_label0;
    logic [15:0]      r_bc_count;

    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_gnt_oh;
    logic             w_found;
    logic [c_PW-1:0]  w_idx;
    logic [c_PW-1:0]  w_ptr_next;
    logic [LW-1:0]    w_gnt_label;
    logic [DW-1:0]    w_gnt_data;

    // The station granted last cycle still shows its stale req this cycle.
    assign w_elig = req & ~r_holdoff;

    cdb_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (c_PW)
    ) u_rr_pick (
        .elig  (w_elig),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    assign w_gnt_oh    = N_REQ'(1) << w_idx;
    assign w_gnt_label = req_label[w_idx*LW +: LW];
    assign w_gnt_data  = req_data[w_idx*DW +: DW];
    assign w_ptr_next  = (w_idx == c_PW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_ack        <= '0;
            r_holdoff    <= '0;
            r_ptr        <= '0;
            r_bcen       <= 1'b0;
            r_bclabel    <= '0;
            r_bcdata     <= '0;
            r_err_label0 <= 1'b0;
            r_bc_count   <= '0;
        end else if (w_found) begin
            r_ack     <= w_gnt_oh;
            r_holdoff <= w_gnt_oh;
            r_ptr     <= w_ptr_next;
            if (w_gnt_label != LW'(c_NO_TAG)) begin
                r_bcen     <= 1'b1;
                r_bclabel  <= w_gnt_label;
                r_bcdata   <= w_gnt_data;
                r_bc_count <= r_bc_count + 16'd1;
            end else begin
                // Untagged result: acknowledge so the station frees, but never broadcast.
                r_bcen       <= 1'b0;
                r_bclabel    <= '0;
                r_bcdata     <= '0;
                r_err_label0 <= 1'b1;
            end
        end else begin
            r_ack     <= '0;
            r_holdoff <= '0;
            r_bcen    <= 1'b0;
            r_bclabel <= '0;
            r_bcdata  <= '0;
        end
    end

    assign ack        = r_ack;
    assign BCEN       = r_bcen;
    assign BClabel    = r_bclabel;
    assign BCdata     = r_bcdata;
    assign err_label0 = r_err_label0;
    assign bc_count   = r_bc_count;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cdb_arbiter                                                |
// | Brief    : Self-checking bench with reactive station model and scoreboard|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int LW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic [LW-1:0] lab;
        logic [DW-1:0] dat;
    } item_t;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [LW-1:0] lab;
        logic [DW-1:0] dat;
    } bc_t;

    logic            clk;
    logic            RST;
    logic [N-1:0]    req;
    logic [N*LW-1:0] req_label;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack;
    logic            BCEN;
    logic [LW-1:0]   BClabel;
    logic [DW-1:0]   BCdata;
    logic            err_label0;
    logic [15:0]     bc_count;

    cdb_arbiter #(.N_REQ(N), .DW(DW), .LW(LW)) u_dut (
        .clk        (clk),
        .RST        (RST),
        .req        (req),
        .req_label  (req_label),
        .req_data   (req_data),
        .ack        (ack),
        .BCEN       (BCEN),
        .BClabel    (BClabel),
        .BCdata     (BCdata),
        .err_label0 (err_label0),
        .bc_count   (bc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    item_t        sq[N][$];
    bc_t          bc_log[$];
    int           ack_cnt[N];
    logic [N-1:0] prev_ack;

    // Reference state: next search start, last granted station, expected outputs.
    int            m_ptr;
    int            m_hold;
    logic [N-1:0]  e_ack;
    logic          e_bcen;
    logic [LW-1:0] e_lab;
    logic [DW-1:0] e_dat;
    logic          e_err;
    logic [15:0]   e_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load(input int i, input logic [LW-1:0] lab, input logic [DW-1:0] dat);
        item_t it;
        it.lab = lab;
        it.dat = dat;
        sq[i].push_back(it);
    endtask

    function automatic void drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (sq[i].size() > 0) begin
                req[i]               = 1'b1;
                req_label[i*LW +: LW] = sq[i][0].lab;
                req_data[i*DW +: DW]  = sq[i][0].dat;
            end else begin
                req[i]               = 1'b0;
                req_label[i*LW +: LW] = '0;
                req_data[i*DW +: DW]  = '0;
            end
        end
    endfunction

    // A station that saw its ack retires the head result and presents the next one.
    function automatic void station_update(input logic [N-1:0] seen);
        for (int i = 0; i < N; i++)
            if (seen[i] && sq[i].size() > 0) void'(sq[i].pop_front());
    endfunction

    task automatic model_edge();
        int g;
        logic [LW-1:0] lab;
        if (RST) begin
            m_ptr  = 0;
            m_hold = -1;
            e_ack  = '0;
            e_bcen = 1'b0;
            e_lab  = '0;
            e_dat  = '0;
            e_err  = 1'b0;
            e_cnt  = '0;
            return;
        end
        g = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (g < 0 && req[j] && j != m_hold) g = j;
        end
        if (g < 0) begin
            e_ack  = '0;
            e_bcen = 1'b0;
            e_lab  = '0;
            e_dat  = '0;
            m_hold = -1;
        end else begin
            e_ack  = N'(1 << g);
            m_ptr  = (g + 1) % N;
            m_hold = g;
            lab    = req_label[g*LW +: LW];
            if (lab != 0) begin
                e_bcen = 1'b1;
                e_lab  = lab;
                e_dat  = req_data[g*DW +: DW];
                e_cnt  = e_cnt + 16'd1;
            end else begin
                e_bcen = 1'b0;
                e_lab  = '0;
                e_dat  = '0;
                e_err  = 1'b1;
            end
        end
    endtask

    task automatic compare();
        bc_t b;
        chk("ack", 64'(ack), 64'(e_ack));
        chk("BCEN", 64'(BCEN), 64'(e_bcen));
        chk("BClabel", 64'(BClabel), 64'(e_lab));
        chk("BCdata", 64'(BCdata), 64'(e_dat));
        chk("err_label0", 64'(err_label0), 64'(e_err));
        chk("bc_count", 64'(bc_count), 64'(e_cnt));
        chk("ack_onehot0", 64'($countones(ack) <= 1), 64'(1));
        chk("bcen_needs_ack", 64'(!(BCEN && ack == '0)), 64'(1));
        chk("idle_bus_zero", 64'(BCEN || (BClabel == '0 && BCdata == '0)), 64'(1));
        if (BCEN) begin
            b.cyc = 32'(cyc);
            b.lab = BClabel;
            b.dat = BCdata;
            bc_log.push_back(b);
        end
        for (int i = 0; i < N; i++) if (ack[i]) ack_cnt[i]++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        station_update(prev_ack);
        drive_inputs();
        compare();
        prev_ack = ack;
    endtask

    function automatic logic busy();
        logic b;
        b = (prev_ack != '0);
        for (int i = 0; i < N; i++) if (sq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic run_until_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        chk({name, "_timeout"}, 64'(busy()), 64'(0));
        step();
    endtask

    task automatic clear_logs();
        bc_log.delete();
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    endtask

    initial begin
        int c0;
        int n;
        RST       = 1'b1;
        req       = '0;
        req_label = '0;
        req_data  = '0;
        prev_ack  = '0;
        m_ptr     = 0;
        m_hold    = -1;
        e_ack     = '0;
        e_bcen    = 1'b0;
        e_lab     = '0;
        e_dat     = '0;
        e_err     = 1'b0;
        e_cnt     = '0;
        clear_logs();

        // Reset held two cycles with every station requesting.
        load(0, c_ADD0, 32'd10);
        load(1, c_ADD1, 32'd20);
        load(2, c_ADD2, 32'd30);
        drive_inputs();
        step();
        step();
        chk("reset_ack", 64'(ack), 64'(0));
        chk("reset_bc_count", 64'(bc_count), 64'(0));
        for (int i = 0; i < N; i++) sq[i].delete();
        drive_inputs();
        RST = 1'b0;
        step();
        chk("post_reset_ack", 64'(ack), 64'(0));
        chk("post_reset_bcen", 64'(BCEN), 64'(0));

        // Round-robin: three stations at once, consecutive broadcasts 1,2,3.
        clear_logs();
        load(0, c_ADD0, 32'd10);
        load(1, c_ADD1, 32'd20);
        load(2, c_ADD2, 32'd30);
        drive_inputs();
        c0 = cyc;
        run_until_idle("rr", 30);
        chk("rr_count", 64'(bc_log.size()), 64'(3));
        if (bc_log.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("rr_label", 64'(bc_log[i].lab), 64'(i + 1));
                chk("rr_data", 64'(bc_log[i].dat), 64'(10 * (i + 1)));
                chk("rr_cycle", 64'(bc_log[i].cyc), 64'(c0 + 1 + i));
            end
        end
        chk("rr_bc_count", 64'(bc_count), 64'(3));

        // Single request: one pulse, one cycle after presentation.
        clear_logs();
        load(0, c_ADD0, 32'h0000_0007);
        drive_inputs();
        c0 = cyc;
        run_until_idle("single", 20);
        step();
        chk("single_pulses", 64'(bc_log.size()), 64'(1));
        chk("single_acks", 64'(ack_cnt[0]), 64'(1));
        if (bc_log.size() >= 1) begin
            chk("single_label", 64'(bc_log[0].lab), 64'(1));
            chk("single_data", 64'(bc_log[0].dat), 64'(7));
            chk("single_latency", 64'(bc_log[0].cyc), 64'(c0 + 1));
        end
        chk("single_bc_count", 64'(bc_count), 64'(4));

        // Holdoff: station 1 re-requests immediately, grants every other cycle.
        clear_logs();
        load(1, 5'd9, 32'd100);
        load(1, 5'd10, 32'd101);
        load(1, 5'd11, 32'd102);
        drive_inputs();
        c0 = cyc;
        run_until_idle("holdoff", 30);
        chk("holdoff_pulses", 64'(bc_log.size()), 64'(3));
        if (bc_log.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("holdoff_label", 64'(bc_log[i].lab), 64'(9 + i));
                chk("holdoff_cycle", 64'(bc_log[i].cyc), 64'(c0 + 1 + 2 * i));
            end
        end
        chk("holdoff_bc_count", 64'(bc_count), 64'(7));

        // Label 0: acked but never broadcast, sticky error.
        clear_logs();
        load(2, c_NO_TAG, 32'hDEAD_BEEF);
        drive_inputs();
        run_until_idle("label0", 20);
        step();
        step();
        chk("label0_acks", 64'(ack_cnt[2]), 64'(1));
        chk("label0_no_bc", 64'(bc_log.size()), 64'(0));
        chk("label0_err", 64'(err_label0), 64'(1));
        chk("label0_bc_count", 64'(bc_count), 64'(7));

        // Reset in the broadcast cycle, then ptr restarts at station 0.
        clear_logs();
        load(1, 5'd12, 32'd55);
        drive_inputs();
        n = 0;
        do begin
            step();
            n++;
        end while (!BCEN && n < 10);
        chk("mid_bcen_seen", 64'(BCEN), 64'(1));
        RST = 1'b1;
        load(0, 5'd13, 32'd130);
        load(2, 5'd14, 32'd140);
        drive_inputs();
        step();
        chk("mid_rst_ack", 64'(ack), 64'(0));
        chk("mid_rst_bcen", 64'(BCEN), 64'(0));
        chk("mid_rst_label", 64'(BClabel), 64'(0));
        chk("mid_rst_err", 64'(err_label0), 64'(0));
        chk("mid_rst_count", 64'(bc_count), 64'(0));
        RST = 1'b0;
        clear_logs();
        run_until_idle("mid", 30);
        chk("mid_pulses", 64'(bc_log.size()), 64'(2));
        if (bc_log.size() == 2) begin
            chk("mid_first", 64'(bc_log[0].lab), 64'(13));
            chk("mid_second", 64'(bc_log[1].lab), 64'(14));
        end
        chk("mid_bc_count", 64'(bc_count), 64'(2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
